// File: rtl/neighbor_builder_pkg.sv
// Shared mesh constants, FSM state encoding and address helpers for the
// neighbor-table builder (and, later, the averager).
package neighbor_builder_pkg;

  localparam int ADDR_WIDTH         = 9;
  localparam int MAX_NEIGHBOR_COUNT = 10;
  localparam int VERTEX_WORDS       = 3;
  localparam int FACE_WORDS         = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FACE_RD,
    EDGE_CNT,
    EDGE_SCAN,
    EDGE_APPEND,
    EDGE_NEXT
  } nb_state_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] dst;
    logic [31:0] nbr;
  } edge_req_t;

  typedef struct packed {
    logic done;
    logic ovf;
  } edge_rsp_t;

  // First object-RAM word of 1-based vertex idx.
  function automatic logic [31:0] vertex_addr(input logic [31:0] idx);
    return idx * 32'(VERTEX_WORDS) - 32'd2;
  endfunction

  // Count slot of 1-based vertex idx in neighbor RAM.
  function automatic logic [31:0] nbr_base(input logic [31:0] idx, input logic [31:0] stride);
    return (idx - 32'd1) * stride;
  endfunction

endpackage

// File: rtl/nbr_list_insert.sv
// Inserts one (dst,nbr) pair into dst's neighbor list: read count, scan list
// for a duplicate, then append nbr and bump count. Owns the neighbor RAM port.
module nbr_list_insert #(
  parameter int ADDR_WIDTH         = neighbor_builder_pkg::ADDR_WIDTH,
  parameter int MAX_NEIGHBOR_COUNT = neighbor_builder_pkg::MAX_NEIGHBOR_COUNT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  neighbor_builder_pkg::edge_req_t    req,
  output neighbor_builder_pkg::edge_rsp_t    rsp,
  output logic                               ram_en,
  output logic [ADDR_WIDTH-1:0]              ram_a,
  output logic [3:0]                         ram_we,
  output logic [31:0]                        ram_di,
  input  logic [31:0]                        ram_do
);
  import neighbor_builder_pkg::*;

  localparam logic [31:0] STRIDE = 32'(MAX_NEIGHBOR_COUNT);

  nb_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic [31:0]           nbr_q, count, iss, cur_cnt;
  logic                  have_cnt, pend, ap_ph;
  logic                  hit, full, scan_issue;

  // Count word lands on the first EDGE_SCAN cycle; after that use the copy.
  assign cur_cnt    = have_cnt ? count : ram_do;
  assign hit        = pend && (ram_do == nbr_q);
  assign full       = (count == STRIDE - 32'd1);
  assign scan_issue = (state == EDGE_SCAN) && !hit && (iss != cur_cnt);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rsp       = '0;
    ram_en    = 1'b0;
    ram_a     = '0;
    ram_we    = 4'b0000;
    ram_di    = '0;
    case (state)
      IDLE: if (req.vld) state_nxt = EDGE_CNT;
      EDGE_CNT: begin
        ram_en    = 1'b1;
        ram_a     = base;
        state_nxt = EDGE_SCAN;
      end
      EDGE_SCAN: begin
        if (hit) begin
          rsp.done  = 1'b1;
          state_nxt = IDLE;
        end else if (iss == cur_cnt) begin
          state_nxt = EDGE_APPEND;
        end else begin
          ram_en = 1'b1;
          ram_a  = base + ADDR_WIDTH'(1) + ADDR_WIDTH'(iss);
        end
      end
      EDGE_APPEND: begin
        if (full) begin
          rsp.ovf   = 1'b1;
          rsp.done  = 1'b1;
          state_nxt = IDLE;
        end else if (!ap_ph) begin
          ram_en = 1'b1;
          ram_we = 4'b1111;
          ram_a  = base + ADDR_WIDTH'(1) + ADDR_WIDTH'(count);
          ram_di = nbr_q;
        end else begin
          ram_en    = 1'b1;
          ram_we    = 4'b1111;
          ram_a     = base;
          ram_di    = count + 32'd1;
          rsp.done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base     <= '0;
      nbr_q    <= '0;
      count    <= '0;
      iss      <= '0;
      have_cnt <= 1'b0;
      pend     <= 1'b0;
      ap_ph    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req.vld) begin
          base     <= ADDR_WIDTH'(nbr_base(req.dst, STRIDE));
          nbr_q    <= req.nbr;
          iss      <= '0;
          have_cnt <= 1'b0;
          pend     <= 1'b0;
          ap_ph    <= 1'b0;
        end
        EDGE_SCAN: begin
          if (!have_cnt) begin
            count    <= ram_do;
            have_cnt <= 1'b1;
          end
          pend <= scan_issue;
          if (scan_issue) iss <= iss + 32'd1;
        end
        EDGE_APPEND: ap_ph <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/neighbor_builder.sv
// Builds the per-vertex neighbor table from the triangle list: clears counts,
// walks faces, and hands each directed edge to nbr_list_insert.
module neighbor_builder #(
  parameter int MAX_NEIGHBOR_COUNT = neighbor_builder_pkg::MAX_NEIGHBOR_COUNT,
  parameter int ADDR_WIDTH         = neighbor_builder_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           vertex_count,
  input  logic [31:0]           face_count,
  input  logic [31:0]           RAM_OBJ_Do,
  input  logic [31:0]           RAM_NBR_Do,
  output logic                  RAM_OBJ_EN,
  output logic                  RAM_NBR_EN,
  output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
  output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
  output logic [3:0]            RAM_OBJ_WE,
  output logic [3:0]            RAM_NBR_WE,
  output logic [31:0]           RAM_OBJ_Di,
  output logic [31:0]           RAM_NBR_Di,
  output logic                  busy,
  output logic                  overflow,
  output logic                  bad_index
);
  import neighbor_builder_pkg::*;

  localparam logic [31:0] STRIDE = 32'(MAX_NEIGHBOR_COUNT);

  nb_state_e             state, state_nxt;
  logic [31:0]           v_total, f_total, f_idx, v_clr;
  logic [ADDR_WIDTH-1:0] face_addr, idx_a, idx_b, idx_c, edge_dst, edge_nbr;
  logic [2:0]            rd_cnt, edge_idx;
  logic                  clr_active, face_bad, last_face;
  edge_req_t             ins_req;
  edge_rsp_t             ins_rsp;
  logic                  ins_en;
  logic [ADDR_WIDTH-1:0] ins_a;
  logic [3:0]            ins_we;
  logic [31:0]           ins_di;
  logic                  unused_obj_hi;

  assign unused_obj_hi = ^RAM_OBJ_Do[31:ADDR_WIDTH];

  assign clr_active = (v_clr < v_total);
  assign last_face  = (f_idx == f_total - 32'd1);
  assign face_bad   = (idx_a == '0) || (32'(idx_a) > v_total) ||
                      (idx_b == '0) || (32'(idx_b) > v_total) ||
                      (idx_c == '0) || (32'(idx_c) > v_total);

  // Edge order: (a,b) (a,c) (b,a) (b,c) (c,a) (c,b).
  always_comb begin
    edge_dst = idx_a;
    edge_nbr = idx_b;
    case (edge_idx)
      3'd0: begin edge_dst = idx_a; edge_nbr = idx_b; end
      3'd1: begin edge_dst = idx_a; edge_nbr = idx_c; end
      3'd2: begin edge_dst = idx_b; edge_nbr = idx_a; end
      3'd3: begin edge_dst = idx_b; edge_nbr = idx_c; end
      3'd4: begin edge_dst = idx_c; edge_nbr = idx_a; end
      3'd5: begin edge_dst = idx_c; edge_nbr = idx_b; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ins_req     = '0;
    ins_req.dst = 32'(edge_dst);
    ins_req.nbr = 32'(edge_nbr);
    RAM_OBJ_EN  = 1'b0;
    RAM_OBJ_A   = '0;
    case (state)
      IDLE:  if (start) state_nxt = CLEAR;
      CLEAR: if (!clr_active) state_nxt = (f_total == '0) ? IDLE : FACE_RD;
      FACE_RD: begin
        if (rd_cnt < 3'd3) begin
          RAM_OBJ_EN = 1'b1;
          RAM_OBJ_A  = face_addr + ADDR_WIDTH'(rd_cnt);
        end
        if (rd_cnt == 3'd4) begin
          if (!face_bad)      state_nxt = EDGE_NEXT;
          else if (last_face) state_nxt = IDLE;
        end
      end
      EDGE_NEXT: begin
        if (edge_idx == 3'd6) begin
          state_nxt = last_face ? IDLE : FACE_RD;
        end else if (edge_dst != edge_nbr) begin
          ins_req.vld = 1'b1;
          state_nxt   = EDGE_CNT;
        end
      end
      // Whole insert runs in the sub-module; the top just waits for done.
      EDGE_CNT: if (ins_rsp.done) state_nxt = EDGE_NEXT;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_total   <= '0;
      f_total   <= '0;
      f_idx     <= '0;
      v_clr     <= '0;
      face_addr <= '0;
      idx_a     <= '0;
      idx_b     <= '0;
      idx_c     <= '0;
      rd_cnt    <= '0;
      edge_idx  <= '0;
      overflow  <= 1'b0;
      bad_index <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          v_total   <= vertex_count;
          f_total   <= face_count;
          v_clr     <= '0;
          overflow  <= 1'b0;
          bad_index <= 1'b0;
        end
        CLEAR: begin
          if (clr_active) begin
            v_clr <= v_clr + 32'd1;
          end else begin
            f_idx     <= '0;
            face_addr <= ADDR_WIDTH'(vertex_addr(v_total + 32'd1));
            rd_cnt    <= '0;
          end
        end
        FACE_RD: begin
          if (rd_cnt != 3'd4) rd_cnt <= rd_cnt + 3'd1;
          case (rd_cnt)
            3'd1: idx_a <= RAM_OBJ_Do[ADDR_WIDTH-1:0];
            3'd2: idx_b <= RAM_OBJ_Do[ADDR_WIDTH-1:0];
            3'd3: idx_c <= RAM_OBJ_Do[ADDR_WIDTH-1:0];
            default: ;
          endcase
          if (rd_cnt == 3'd4) begin
            edge_idx <= '0;
            if (face_bad) begin
              bad_index <= 1'b1;
              f_idx     <= f_idx + 32'd1;
              face_addr <= face_addr + ADDR_WIDTH'(FACE_WORDS);
              rd_cnt    <= '0;
            end
          end
        end
        EDGE_NEXT: begin
          if (edge_idx == 3'd6) begin
            f_idx     <= f_idx + 32'd1;
            face_addr <= face_addr + ADDR_WIDTH'(FACE_WORDS);
            rd_cnt    <= '0;
          end else if (edge_dst == edge_nbr) begin
            edge_idx <= edge_idx + 3'd1;
          end
        end
        EDGE_CNT: if (ins_rsp.done) begin
          edge_idx <= edge_idx + 3'd1;
          if (ins_rsp.ovf) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  nbr_list_insert #(
    .ADDR_WIDTH         (ADDR_WIDTH),
    .MAX_NEIGHBOR_COUNT (MAX_NEIGHBOR_COUNT)
  ) u_ins (
    .clk    (clk),
    .rst    (rst),
    .req    (ins_req),
    .rsp    (ins_rsp),
    .ram_en (ins_en),
    .ram_a  (ins_a),
    .ram_we (ins_we),
    .ram_di (ins_di),
    .ram_do (RAM_NBR_Do)
  );

  // CLEAR writes count slots directly; every other NBR access is the insert's.
  always_comb begin
    if (state == CLEAR && clr_active) begin
      RAM_NBR_EN = 1'b1;
      RAM_NBR_WE = 4'b1111;
      RAM_NBR_A  = ADDR_WIDTH'(v_clr * STRIDE);
      RAM_NBR_Di = '0;
    end else begin
      RAM_NBR_EN = ins_en;
      RAM_NBR_WE = ins_we;
      RAM_NBR_A  = ins_a;
      RAM_NBR_Di = ins_di;
    end
  end

  assign RAM_OBJ_WE = 4'b0000;
  assign RAM_OBJ_Di = '0;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_neighbor_builder.sv
// Randomised and directed bench for neighbor_builder: a list-based model
// predicts the exact NBR write stream, final table and sticky flags.
module tb_neighbor_builder;
  localparam int M  = 10;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [31:0]   vertex_count, face_count, obj_do, nbr_do;
  logic          RAM_OBJ_EN, RAM_NBR_EN, busy, overflow, bad_index;
  logic [AW-1:0] RAM_OBJ_A, RAM_NBR_A;
  logic [3:0]    RAM_OBJ_WE, RAM_NBR_WE;
  logic [31:0]   RAM_OBJ_Di, RAM_NBR_Di;

  always #5 clk = ~clk;

  neighbor_builder #(.MAX_NEIGHBOR_COUNT(M), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .vertex_count(vertex_count), .face_count(face_count),
    .RAM_OBJ_Do(obj_do), .RAM_NBR_Do(nbr_do),
    .RAM_OBJ_EN(RAM_OBJ_EN), .RAM_NBR_EN(RAM_NBR_EN),
    .RAM_OBJ_A(RAM_OBJ_A), .RAM_NBR_A(RAM_NBR_A),
    .RAM_OBJ_WE(RAM_OBJ_WE), .RAM_NBR_WE(RAM_NBR_WE),
    .RAM_OBJ_Di(RAM_OBJ_Di), .RAM_NBR_Di(RAM_NBR_Di),
    .busy(busy), .overflow(overflow), .bad_index(bad_index)
  );

  logic [31:0] obj_mem [512];
  logic [31:0] nbr_mem [512];
  logic        scramble = 1'b0;

  // Synchronous single-port RAMs; scramble fills the neighbor RAM with junk.
  always @(posedge clk) begin
    if (RAM_OBJ_EN && RAM_OBJ_WE == 4'b0) obj_do <= obj_mem[RAM_OBJ_A];
    if (scramble) begin
      for (int i = 0; i < 512; i++) nbr_mem[i] = $urandom;
    end else if (RAM_NBR_EN) begin
      if (RAM_NBR_WE == 4'hF) nbr_mem[RAM_NBR_A] = RAM_NBR_Di;
      else                    nbr_do <= nbr_mem[RAM_NBR_A];
    end
  end

  int tests = 0, fails = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-vertex lists and the ordered writes that build them.
  int fa[$], fb[$], fc[$];
  int m_cnt [16];
  int m_list[16][M];
  bit m_ovf, m_bad;
  int exp_a[$], exp_d[$];

  function automatic void build_model(input int V);
    int d[6], n[6];
    bit found;
    exp_a.delete(); exp_d.delete();
    m_ovf = 0; m_bad = 0;
    for (int v = 0; v < 16; v++) m_cnt[v] = 0;
    for (int v = 0; v < V; v++) begin exp_a.push_back(v * M); exp_d.push_back(0); end
    for (int f = 0; f < fa.size(); f++) begin
      int a, b, c;
      a = fa[f] & 511; b = fb[f] & 511; c = fc[f] & 511;
      if (a == 0 || b == 0 || c == 0 || a > V || b > V || c > V) begin
        m_bad = 1;
        continue;
      end
      d = '{a, a, b, b, c, c};
      n = '{b, c, a, c, a, b};
      for (int e = 0; e < 6; e++) begin
        if (d[e] == n[e]) continue;
        found = 0;
        for (int i = 0; i < m_cnt[d[e]]; i++) if (m_list[d[e]][i] == n[e]) found = 1;
        if (found) continue;
        if (m_cnt[d[e]] == M - 1) begin m_ovf = 1; continue; end
        m_list[d[e]][m_cnt[d[e]]] = n[e];
        exp_a.push_back((d[e] - 1) * M + 1 + m_cnt[d[e]]); exp_d.push_back(n[e]);
        m_cnt[d[e]]++;
        exp_a.push_back((d[e] - 1) * M); exp_d.push_back(m_cnt[d[e]]);
      end
    end
  endfunction

  bit mon_en = 0, wr_chk = 0;
  bit prev_busy;
  int falls = 0;

  always @(negedge clk) begin
    prev_busy <= busy;
    if (prev_busy && !busy) falls++;
  end

  // Per-cycle compare: port invariants and every NBR write against the model.
  always @(negedge clk) if (mon_en) begin
    bit inv;
    inv = (RAM_OBJ_WE == 4'h0) && (RAM_OBJ_Di == 32'h0) &&
          (RAM_NBR_WE == 4'h0 || RAM_NBR_WE == 4'hF) &&
          (busy || (!RAM_OBJ_EN && !RAM_NBR_EN && RAM_OBJ_A == '0 && RAM_NBR_A == '0 &&
                    RAM_NBR_WE == 4'h0 && RAM_NBR_Di == 32'h0));
    check(inv, "port_invariant", {RAM_NBR_EN, RAM_NBR_WE}, 0);
    if (wr_chk && RAM_NBR_WE == 4'hF) begin
      if (exp_a.size() == 0) begin
        check(0, "unexpected_write_addr", RAM_NBR_A, -1);
      end else begin
        int ea, ed;
        ea = exp_a.pop_front(); ed = exp_d.pop_front();
        check(RAM_NBR_A == AW'(ea), "write_addr", RAM_NBR_A, ea);
        check(RAM_NBR_Di == 32'(ed), "write_data", RAM_NBR_Di, ed);
      end
    end
  end

  task automatic load_obj(input int V);
    for (int i = 0; i < 512; i++) obj_mem[i] = $urandom;
    for (int f = 0; f < fa.size(); f++) begin
      obj_mem[3 * V + 1 + 3 * f] = fa[f];
      obj_mem[3 * V + 2 + 3 * f] = fb[f];
      obj_mem[3 * V + 3 + 3 * f] = fc[f];
    end
    vertex_count = V;
    face_count   = fa.size();
    scramble = 1'b1; @(negedge clk); scramble = 1'b0;
  endtask

  task automatic run_mesh(input int V, input int extra_at, output int lat);
    int f0;
    build_model(V);
    load_obj(V);
    f0 = falls;
    wr_chk = 1;
    start = 1'b1; @(negedge clk); start = 1'b0;
    check(busy == 1'b1, "busy_rise", busy, 1);
    lat = 0;
    while (busy && lat < 20000) begin
      start = (lat == extra_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check(lat < 20000, "done_timeout", lat, 20000);
    repeat (3) @(negedge clk);
    check(falls - f0 == 1, "busy_falls", falls - f0, 1);
    check(exp_a.size() == 0, "writes_missing", exp_a.size(), 0);
    check(overflow == m_ovf, "overflow", overflow, m_ovf);
    check(bad_index == m_bad, "bad_index", bad_index, m_bad);
    for (int v = 1; v <= V; v++) begin
      bit ok;
      int b;
      b = (v - 1) * M;
      ok = (nbr_mem[b] == 32'(m_cnt[v]));
      for (int i = 0; i < m_cnt[v]; i++) ok &= (nbr_mem[b + 1 + i] == 32'(m_list[v][i]));
      check(ok, "table", nbr_mem[b], m_cnt[v]);
    end
    wr_chk = 0;
  endtask

  task automatic pin(input int addr, input int expv);
    check(nbr_mem[addr] == 32'(expv), "pin_nbr", nbr_mem[addr], expv);
  endtask

  task automatic pin_tri();
    pin(0, 2);  pin(1, 2);  pin(2, 3);
    pin(10, 2); pin(11, 1); pin(12, 3);
    pin(20, 2); pin(21, 1); pin(22, 2);
  endtask

  initial begin
    int lat, lat_b, n;
    rst = 1'b1; start = 1'b0; vertex_count = 0; face_count = 0;
    repeat (3) @(negedge clk);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(overflow == 1'b0 && bad_index == 1'b0, "rst_flags", {overflow, bad_index}, 0);
    check(!RAM_NBR_EN && RAM_NBR_WE == 0 && !RAM_OBJ_EN && RAM_NBR_A == 0 && RAM_OBJ_A == 0,
          "rst_ports", {RAM_NBR_EN, RAM_NBR_WE, RAM_OBJ_EN}, 0);
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);

    // Single triangle
    fa = '{1}; fb = '{2}; fc = '{3};
    run_mesh(3, -1, lat);
    pin_tri();
    check(overflow == 1'b0 && bad_index == 1'b0, "tri_flags", {overflow, bad_index}, 0);

    // Two triangles sharing edge 1-3, then the same with a stray start
    fa = '{1, 1}; fb = '{2, 3}; fc = '{3, 4};
    run_mesh(4, -1, lat);
    pin(0, 3);  pin(1, 2);  pin(2, 3);  pin(3, 4);
    pin(10, 2); pin(11, 1); pin(12, 3);
    pin(20, 3); pin(21, 1); pin(22, 2); pin(23, 4);
    pin(30, 2); pin(31, 1); pin(32, 3);
    run_mesh(4, 20, lat_b);
    check(lat_b == lat, "busy_start_latency", lat_b, lat);

    // Fan around vertex 1 overflows its list; last face references vertex 12
    fa.delete(); fb.delete(); fc.delete();
    for (int k = 2; k <= 11; k++) begin fa.push_back(1); fb.push_back(k); fc.push_back(k + 1); end
    run_mesh(11, -1, lat);
    pin(0, 9);
    for (int i = 1; i <= 9; i++) pin(i, i + 1);
    check(overflow == 1'b1, "fan_overflow", overflow, 1);

    // Bad face skipped
    fa = '{1, 0}; fb = '{2, 2}; fc = '{3, 5};
    run_mesh(3, -1, lat);
    pin_tri();
    check(bad_index == 1'b1, "skip_bad_index", bad_index, 1);

    // F=0 and V=0 corners
    fa.delete(); fb.delete(); fc.delete();
    run_mesh(5, -1, lat);
    fa = '{1, 2}; fb = '{2, 3}; fc = '{3, 1};
    run_mesh(0, -1, lat);

    // Reset in the middle of an append, then rebuild from scratch
    fa = '{0, 1}; fb = '{1, 2}; fc = '{2, 3};
    build_model(3);
    load_obj(3);
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (!(RAM_NBR_WE == 4'hF && (RAM_NBR_A % M) != 0) && n < 2000) begin @(negedge clk); n++; end
    check(n < 2000, "append_timeout", n, 2000);
    check(bad_index == 1'b1, "pre_rst_bad", bad_index, 1);
    rst = 1'b1; @(negedge clk);
    check(busy == 1'b0 && RAM_NBR_WE == 4'h0, "rst_mid_append", {busy, RAM_NBR_WE}, 0);
    check(bad_index == 1'b0, "rst_clears_flag", bad_index, 0);
    rst = 1'b0; @(negedge clk);
    fa = '{1}; fb = '{2}; fc = '{3};
    run_mesh(3, -1, lat);
    pin_tri();

    // Random meshes
    for (int t = 0; t < 10; t++) begin
      int V, F;
      V = $urandom_range(1, 13);
      F = $urandom_range(0, 12);
      fa.delete(); fb.delete(); fc.delete();
      for (int f = 0; f < F; f++) begin
        bit wild;
        wild = ($urandom_range(0, 7) == 0);
        fa.push_back(wild ? $urandom_range(0, V + 1) : $urandom_range(1, V));
        fb.push_back($urandom_range(1, V));
        fc.push_back(wild ? $urandom_range(0, V + 1) : $urandom_range(1, V));
      end
      run_mesh(V, (t % 3 == 0) ? 7 : -1, lat);
    end

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/neighbor_builder.md
Name: neighbor_builder

Overview:
Builds the per-vertex neighbor table in neighbor RAM from the triangle face list in object RAM. The averager and later subdivision passes read this table. Runs once per mesh, before averaging. It writes exactly the table layout the averager reads:
- Slot v*MAX_NEIGHBOR_COUNT holds the count.
- The following slots hold 1-based neighbor vertex indices, with no duplicates.

Parameters:
MAX_NEIGHBOR_COUNT, 10, words per vertex record in neighbor RAM (1 count + up to MAX_NEIGHBOR_COUNT-1 neighbors)
ADDR_WIDTH, 9, RAM address width

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; accepted only when busy=0
vertex_count  in  32  number of vertices V
face_count  in  32  number of triangles F
RAM_OBJ_Do  in  32  object RAM read data
RAM_NBR_Do  in  32  neighbor RAM read data
RAM_OBJ_EN, RAM_NBR_EN  out  1  RAM enables
RAM_OBJ_A, RAM_NBR_A  out  ADDR_WIDTH  RAM addresses
RAM_OBJ_WE, RAM_NBR_WE  out  4  byte write enables (RAM_OBJ_WE constant 0)
RAM_OBJ_Di, RAM_NBR_Di  out  32  write data (RAM_OBJ_Di constant 0)
busy  out  1  high from the cycle after start accept until done
overflow  out  1  sticky; a neighbor was dropped because a list was full
bad_index  out  1  sticky; a face was skipped

Behaviour:
- Reset / memory layout:
  - Reset, and IDLE: busy=0, all EN/WE/A/Di=0. overflow and bad_index are cleared only by rst or an accepted start.
  - RAMs are synchronous: read data appears on Do the cycle after A is presented with EN=1, WE=0. A write occurs in the cycle WE=4'b1111.
  - Vertex v (1-based) occupies object RAM addresses 3v-2..3v.
  - Face f (0-based) occupies object RAM addresses 3V+1+3f..3V+3+3f: three 1-based vertex indices a,b,c, low ADDR_WIDTH bits used.
- FSM: IDLE, CLEAR, FACE_RD, EDGE_CNT, EDGE_SCAN, EDGE_APPEND, EDGE_NEXT.
  - IDLE: on start, go to CLEAR. busy=1 from the next cycle.
  - CLEAR: write 0 to address v*MAX_NEIGHBOR_COUNT for v=0..V-1, one write per cycle. If F=0, go to IDLE; else go to FACE_RD with f=0.
  - FACE_RD: issue 3 consecutive reads, capture a,b,c.
    - If any index is 0 or >V: set bad_index, skip the face.
    - Else start the edge sequence in fixed order: (dst a, nbr b), (a,c), (b,a), (b,c), (c,a), (c,b).
    - Edges with dst==nbr are skipped without RAM access.
  - EDGE_CNT: read count at base=(dst-1)*MAX_NEIGHBOR_COUNT.
  - EDGE_SCAN: read base+1..base+count, pipelined one per cycle; compare each returned word with nbr.
    - On match: abandon the edge, go to EDGE_NEXT.
    - count=0: go straight to EDGE_APPEND.
  - EDGE_APPEND:
    - If count == MAX_NEIGHBOR_COUNT-1: set overflow, no write.
    - Else write nbr to base+1+count in cycle 1, then count+1 to base in cycle 2.
  - EDGE_NEXT: next edge; after 6 edges go to f+1. After f==F-1: WE=0, busy=0, go to IDLE.
- Count is compared as a full 32-bit value. The address arithmetic is truncated to ADDR_WIDTH bits.
- start while busy=1: ignored.
- rst mid-operation: outputs return to reset values on the next edge. Any partial table is abandoned; no write is issued after rst.
- V=0: CLEAR does nothing. Faces are still read, and all are flagged bad_index.
- Write and read never target the same RAM in the same cycle.

Decomposition:
- Shared package (e.g. mesh_pkg):
  - ADDR_WIDTH, MAX_NEIGHBOR_COUNT, VERTEX_WORDS=3, FACE_WORDS=3.
  - State enum.
  - Address helper functions: vertex_addr(idx)=3idx-2, nbr_base(idx)=(idx-1)*MAX_NEIGHBOR_COUNT.
  The averager migrates to this package later.
- One natural sub-module: nbr_list_insert. It implements EDGE_CNT/SCAN/APPEND for one (dst,nbr) pair with req/done handshake and owns the NBR RAM port. The top FSM owns the OBJ RAM port.

Test Plan:
- V=3, F=1, face (1,2,3) -> NBR[0..2]={2,2,3}, NBR[10..12]={2,1,3}, NBR[20..22]={2,1,2}; overflow=0, bad_index=0; busy falls once.
- V=4, F=2, faces (1,2,3),(1,3,4) -> v1 count 3 list {2,3,4}; v3 count 3 list {1,2,4}; v2 count 2 {1,3}; v4 count 2 {1,3}; no duplicates written.
- V=11, fan of 10 faces (1,k,k+1) k=2..11 -> NBR[0]=9, entries 2..10 in order, overflow=1; other counts correct.
- V=3, F=2, faces (1,2,3),(0,2,5) -> second face skipped, bad_index=1, table equals the single-triangle result.
- rst asserted mid EDGE_APPEND -> busy=0, WE=0 next cycle; a fresh start rebuilds the correct table with flags cleared.
- start pulsed while busy=1 -> no restart; final table and busy-fall cycle identical to the run without the extra pulse.
